// File: rtl/noc_params.sv
// Shared mesh parameters and flit/port types for the credit-based router tile.
package noc_params;

    localparam int PORT_NUM    = 5;
    localparam int MESH_SIZE_X = 4;
    localparam int MESH_SIZE_Y = 4;
    localparam int COORD_W     = $clog2((MESH_SIZE_X > MESH_SIZE_Y) ? MESH_SIZE_X : MESH_SIZE_Y);
    localparam int PAYLOAD_W   = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_t;

    // Destination fields are only meaningful on HEAD/HEADTAIL flits.
    typedef struct packed {
        flit_label_t            label;
        logic [COORD_W-1:0]     x_dest;
        logic [COORD_W-1:0]     y_dest;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    function automatic logic is_head(flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/credit_input_fifo.sv
// Per-port input buffer: circular FIFO with wrap-bit pointers and a sticky overflow flag.
module credit_input_fifo
    import noc_params::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t data_in,
    output flit_t data_out,
    output logic  empty,
    output logic  full,
    output logic  overflow
);

    localparam int AW = $clog2(DEPTH);

    flit_t        mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr[AW-1:0]];

    // A push while full is dropped even if a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/credit_router.sv
// Five-port single-VC wormhole mesh router with credit-based flow control.
// Output FSM, one per output port:
//   state  | meaning
//   IDLE   | no packet owns the output; arbitrate among routed head flits
//   LOCKED | output owned by input 'owner' until its TAIL flit is sent
module credit_router
    import noc_params::*;
#(
    parameter int BUFFER_SIZE      = 8,
    parameter int DOWN_BUFFER_SIZE = 8,
    parameter int X_CURRENT        = MESH_SIZE_X / 2,
    parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
    parameter bit ROUTING_YX       = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               data_i     [PORT_NUM],
    input  logic [PORT_NUM-1:0] valid_i,
    output logic [PORT_NUM-1:0] credit_o,
    output flit_t               data_o     [PORT_NUM],
    output logic [PORT_NUM-1:0] valid_o,
    input  logic [PORT_NUM-1:0] credit_i,
    output logic [PORT_NUM-1:0] err_o,
    output logic [PORT_NUM-1:0] cred_err_o
);

    localparam int                 CW       = $clog2(DOWN_BUFFER_SIZE + 1);
    localparam logic [CW-1:0]      CRED_MAX = CW'(DOWN_BUFFER_SIZE);
    localparam logic [COORD_W-1:0] XC       = COORD_W'(X_CURRENT);
    localparam logic [COORD_W-1:0] YC       = COORD_W'(Y_CURRENT);

    flit_t               head  [PORT_NUM];
    port_t               route [PORT_NUM];
    logic [PORT_NUM-1:0] empty;
    logic [PORT_NUM-1:0] fifo_full_unused;
    logic [PORT_NUM-1:0] pop;

    out_state_t          state      [PORT_NUM];
    out_state_t          nxt_state  [PORT_NUM];
    port_t               owner      [PORT_NUM];
    port_t               nxt_owner  [PORT_NUM];
    port_t               ptr        [PORT_NUM];
    port_t               nxt_ptr    [PORT_NUM];
    logic [PORT_NUM-1:0] send;
    port_t               src        [PORT_NUM];
    logic [CW-1:0]       credit_cnt [PORT_NUM];

    function automatic port_t route_of(flit_t f);
        port_t x_dir;
        port_t y_dir;
        logic  x_eq;
        logic  y_eq;
        x_dir = (f.x_dest > XC) ? EAST : WEST;
        y_dir = (f.y_dest > YC) ? SOUTH : NORTH;
        x_eq  = (f.x_dest == XC);
        y_eq  = (f.y_dest == YC);
        if (x_eq && y_eq) return LOCAL;
        if (ROUTING_YX)   return y_eq ? x_dir : y_dir;
        return x_eq ? y_dir : x_dir;
    endfunction

    function automatic port_t rr_index(port_t base, int k);
        logic [3:0] s;
        s = {1'b0, base} + 4'(k);
        if (s >= 4'(PORT_NUM)) s = s - 4'(PORT_NUM);
        return port_t'(s[2:0]);
    endfunction

    function automatic port_t next_port(port_t p);
        return (p == EAST) ? LOCAL : port_t'(p + 3'd1);
    endfunction

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
        credit_input_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (valid_i[p]),
            .pop      (pop[p]),
            .data_in  (data_i[p]),
            .data_out (head[p]),
            .empty    (empty[p]),
            .full     (fifo_full_unused[p]),
            .overflow (err_o[p])
        );
        assign route[p] = route_of(head[p]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                state[o] <= IDLE;
                owner[o] <= LOCAL;
                ptr[o]   <= LOCAL;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                state[o] <= nxt_state[o];
                owner[o] <= nxt_owner[o];
                ptr[o]   <= nxt_ptr[o];
            end
        end
    end

    // A locked owner holds the output while its FIFO runs dry or credits are out.
    always_comb begin
        port_t idx;
        idx = LOCAL;
        for (int o = 0; o < PORT_NUM; o++) begin
            send[o] = 1'b0;
            src[o]  = owner[o];
            if (credit_cnt[o] != '0) begin
                if (state[o] == LOCKED) begin
                    send[o] = !empty[owner[o]];
                end else begin
                    for (int k = 0; k < PORT_NUM; k++) begin
                        idx = rr_index(ptr[o], k);
                        if (!send[o] && !empty[idx] && is_head(head[idx].label) &&
                            route[idx] == port_t'(3'(o))) begin
                            send[o] = 1'b1;
                            src[o]  = idx;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            nxt_state[o] = state[o];
            nxt_owner[o] = owner[o];
            nxt_ptr[o]   = ptr[o];
            if (send[o]) begin
                if (state[o] == IDLE) begin
                    nxt_ptr[o] = next_port(src[o]);
                    if (head[src[o]].label == HEAD) begin
                        nxt_state[o] = LOCKED;
                        nxt_owner[o] = src[o];
                    end
                end else if (head[src[o]].label == TAIL) begin
                    nxt_state[o] = IDLE;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (send[o]) pop[src[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o  <= '0;
            credit_o <= '0;
            for (int o = 0; o < PORT_NUM; o++) data_o[o] <= '0;
        end else begin
            valid_o  <= send;
            credit_o <= pop;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (send[o]) data_o[o] <= head[src[o]];
            end
        end
    end

    // Simultaneous send and returned credit cancel; a credit at full count is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cred_err_o <= '0;
            for (int o = 0; o < PORT_NUM; o++) credit_cnt[o] <= CRED_MAX;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (send[o] && !credit_i[o]) begin
                    credit_cnt[o] <= credit_cnt[o] - 1'b1;
                end else if (credit_i[o] && !send[o]) begin
                    if (credit_cnt[o] == CRED_MAX) cred_err_o[o] <= 1'b1;
                    else                           credit_cnt[o] <= credit_cnt[o] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/credit_router.md
Name: credit_router

Overview:
- Parametrised single-VC wormhole mesh router; next generation of the NoC router tile.
- Replaces on/off flow control with credit-based flow control.
- Routing order (XY or YX) is selectable per instance.
- Five ports: LOCAL, NORTH, SOUTH, WEST, EAST. Each port has an input FIFO, a per-output wormhole lock, round-robin switch arbitration and a registered output stage.

Parameters:
BUFFER_SIZE, 8, input FIFO depth per port (power of two, >=2)
DOWN_BUFFER_SIZE, 8, downstream buffer depth; initial and maximum credit count per output
X_CURRENT, MESH_SIZE_X/2, router x coordinate
Y_CURRENT, MESH_SIZE_Y/2, router y coordinate
ROUTING_YX, 0, 0 = XY dimension order, 1 = YX dimension order

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
data_i  input  flit_t [PORT_NUM]  incoming flit per port
valid_i  input  [PORT_NUM]  data_i[p] valid this cycle
credit_o  output  [PORT_NUM]  one-cycle pulse: one slot freed in input FIFO p
data_o  output  flit_t [PORT_NUM]  outgoing flit per port
valid_o  output  [PORT_NUM]  data_o[p] valid
credit_i  input  [PORT_NUM]  one credit returned by downstream of output p
err_o  output  [PORT_NUM]  sticky: input FIFO p overflow
cred_err_o  output  [PORT_NUM]  sticky: credit_i[p] received with counter already at DOWN_BUFFER_SIZE

Behaviour:
- Reset (rst=0, async):
  - FIFOs empty; all outputs IDLE; round-robin pointers = LOCAL.
  - Credit counters = DOWN_BUFFER_SIZE.
  - data_o=0, valid_o=0, credit_o=0, err_o=0, cred_err_o=0.
  - A packet in flight when reset asserts is discarded and its lock cleared.
- Input side:
  - valid_i[p] pushes data_i[p] at the clock edge.
  - Push while full: flit dropped, err_o[p] set (stays set until reset).
  - Push and pop in the same cycle on a full FIFO is an overflow; the upstream credit protocol prevents it.
- Route computation: combinational on the FIFO head flit when its label is HEAD or HEADTAIL.
  - XY order: x_dest>X_CURRENT -> EAST; x_dest<X_CURRENT -> WEST; else y_dest>Y_CURRENT -> SOUTH; y_dest<Y_CURRENT -> NORTH; else LOCAL.
  - YX order: compare y first, then x.
  - Route is latched per input at grant and reused for the BODY/TAIL flits of the same packet.
- Output FSM, per output o: IDLE or LOCKED(owner).
  - IDLE: requesters are inputs whose head flit is HEAD/HEADTAIL routed to o.
    - Grant only if credit[o]>0.
    - Winner chosen round-robin starting at ptr[o]; ptr[o] <= winner+1 mod PORT_NUM.
    - The granted flit is sent the same cycle.
    - HEAD -> LOCKED(winner). HEADTAIL -> remain IDLE.
  - LOCKED: sends owner's FIFO head when the FIFO is non-empty and credit[o]>0; otherwise stalls with no bubble penalty.
    - TAIL sent -> IDLE; a new arbitration is allowed the next cycle.
  - An input is granted by at most one output per cycle, which holds by construction since each head has exactly one route.
- Send action:
  - Pop the input FIFO.
  - credit[o]--.
  - data_o[o]/valid_o[o] registered: visible next cycle.
  - credit_o[input] pulses next cycle.
  - A cycle with no send drives valid_o[o]=0; data_o holds its last value.
- Credits: counter width $clog2(DOWN_BUFFER_SIZE+1).
  - Send and credit_i in the same cycle -> count unchanged.
  - credit_i at maximum with no send -> counter saturates, cred_err_o[o] set.
- Latency: flit arriving on valid_i at edge t is stored at t, sent at t+1, and appears on valid_o at t+2. Zero-load per-hop latency is 2 cycles.
- Throughput: 1 flit/cycle/output when credits are available.
- A BODY/TAIL flit at the head of an input with no lock (protocol error) is never granted and blocks that input.

Decomposition:
- noc_params package holds:
  - PORT_NUM, MESH_SIZE_X, MESH_SIZE_Y.
  - port_t enum {LOCAL, NORTH, SOUTH, WEST, EAST}.
  - flit_label_t {HEAD, BODY, TAIL, HEADTAIL}.
  - flit_t: label; x_dest/y_dest in head; payload.
- Sub-module credit_input_fifo: circular buffer with read/write pointers and a full/empty extra bit; ports push, pop, data, empty, full, overflow. Instantiated PORT_NUM times.
- Routing function, round-robin arbiter and credit counters live in credit_router.

Test Plan:
- Reset, idle: valid_i=0 for 10 cycles -> valid_o=0, credit_o=0, all credit counters=8, err flags 0.
- Single HEADTAIL on LOCAL, dest (X_CURRENT+1, Y_CURRENT), XY -> valid_o[EAST]=1 exactly 2 cycles after injection; credit_o[LOCAL] pulses once, 1 cycle after the send; credit[EAST]=7.
- ROUTING_YX=1, head dest (X+1, Y+1) on WEST -> exits SOUTH; the same stimulus with ROUTING_YX=0 exits EAST.
- 4-flit packets from NORTH and WEST injected in the same cycle, both to LOCAL -> NORTH's packet wins first; its 4 flits go out back-to-back, then WEST's 4. No flit interleaving.
- DOWN_BUFFER_SIZE=2, credit_i held 0 -> EAST sends 2 flits then stalls. Return one credit_i -> exactly one more flit.
- Push 9 flits into a BUFFER_SIZE=8 input with its output blocked -> err_o[p]=1 on the 9th flit, 8 flits retained. Assert rst mid-packet -> all outputs IDLE and err_o cleared.
